mux_nto1_reg_scan: RTL and testbench

- Parametrised N-channel, W-bit-wide multiplexer with an active-low enable.
- Successor to the fixed 32:1 single-bit mux tree. Adds a registered output stage with a valid/ready handshake, and an auto-scan mode in which an internal counter walks all channels.
- Sits between a bank of sampled sources and a single downstream consumer, for example a serialiser or logger.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_nto1_comb.sv | 26 ++
 rtl/mux_nto1_reg_scan.sv | 130 +++++++++++++
 tb/tb_mux_nto1_reg_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered scanning multiplexer.
// Holds the mode encodings and the output-stage state enum.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Output-stage state, also useful when probing the block in debug.
    typedef enum logic [1:0] {
        DIS   = 2'd0,
        EMPTY = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage : mux_pkg

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 channel selector.
// Returns zero data and legal=0 when sel addresses a channel that does not exist.
module mux_nto1_comb #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 32,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          data,
    output logic                      legal
);

    // One-hot style compare per channel keeps out-of-range selects harmless.
    always_comb begin
        data  = '0;
        legal = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                data  = in[k*WIDTH +: WIDTH];
                legal = 1'b1;
            end
        end
    end

endmodule : mux_nto1_comb

// File: rtl/mux_nto1_reg_scan.sv
// N-channel W-bit mux with registered valid/ready output and an auto-scan mode.
// Holds the handshake register, scan counter, registered mode and error flag.
module mux_nto1_reg_scan
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 32,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      enable,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      scan_wrap,
    output logic                      sel_err
);

    localparam int unsigned LAST_CH = CHANNELS - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               scan_wrap_q, scan_wrap_d;
    logic               sel_err_q, sel_err_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;

    logic               scan;
    logic               restart;
    logic               take;
    logic [SEL_W-1:0]   cnt_eff;
    logic [SEL_W-1:0]   ch;
    logic [WIDTH-1:0]   mux_data;
    logic               mux_legal;

    // Capture qualification and channel choice for this cycle.
    always_comb begin
        scan    = (mode == MODE_SCAN);
        restart = (mode != mode_q);
        take    = !enable && ((state_q != FULL) || out_ready);
        cnt_eff = restart ? '0 : cnt_q;
        ch      = scan ? cnt_eff : sel;
    end

    mux_nto1_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .in    (in),
        .sel   (ch),
        .data  (mux_data),
        .legal (mux_legal)
    );

    // Next-state and output-stage update; stall falls through to the hold defaults.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        scan_wrap_d = scan_wrap_q;
        sel_err_d   = 1'b0;
        cnt_d       = cnt_q;
        mode_d      = mode;

        if (enable) begin
            state_d     = DIS;
            out_d       = '0;
            out_valid_d = 1'b0;
            scan_wrap_d = 1'b0;
        end else if (take) begin
            if (scan) begin
                cnt_d = (cnt_eff == SEL_W'(LAST_CH)) ? '0 : cnt_eff + SEL_W'(1);
            end else if (restart) begin
                cnt_d = '0;
            end

            if (mux_legal) begin
                state_d     = FULL;
                out_d       = mux_data;
                out_ch_d    = ch;
                out_valid_d = 1'b1;
                scan_wrap_d = scan && (ch == SEL_W'(LAST_CH));
            end else begin
                // Out-of-range direct select: drop to empty and flag it.
                state_d     = EMPTY;
                out_d       = '0;
                out_valid_d = 1'b0;
                scan_wrap_d = 1'b0;
                sel_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
            sel_err_q   <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= MODE_DIRECT;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            scan_wrap_q <= scan_wrap_d;
            sel_err_q   <= sel_err_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign scan_wrap = scan_wrap_q;
    assign sel_err   = sel_err_q;

endmodule : mux_nto1_reg_scan

// File: tb/tb_mux_nto1_reg_scan.sv
// Scoreboard bench: a 32-channel and a 20-channel instance share all stimulus;
// each has a behavioural model whose predicted output snapshots a monitor pops and checks.
module tb_mux_nto1_reg_scan;

    localparam int unsigned W = 8;

    typedef struct {
        int         cnt;
        bit         mode_q;
        bit         valid;
        logic [7:0] data;
        int         ch;
        bit         wrap;
        bit         err;
    } mstate_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*W-1:0]   in_bus;
    logic [4:0]        sel;
    logic              mode;
    logic              enable;
    logic              out_ready;

    logic [W-1:0]      o32, o20;
    logic              v32, v20;
    logic [4:0]        ch32, ch20;
    logic              w32, w20;
    logic              e32, e20;

    mstate_t           m32, m20;
    mstate_t           q32[$];
    mstate_t           q20[$];
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    mux_nto1_reg_scan #(.WIDTH(W), .CHANNELS(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in        (in_bus),
        .sel       (sel),
        .mode      (mode),
        .enable    (enable),
        .out_ready (out_ready),
        .out       (o32),
        .out_valid (v32),
        .out_ch    (ch32),
        .scan_wrap (w32),
        .sel_err   (e32)
    );

    mux_nto1_reg_scan #(.WIDTH(W), .CHANNELS(20)) u_dut20 (
        .clk       (clk),
        .rst       (rst),
        .in        (in_bus[20*W-1:0]),
        .sel       (sel),
        .mode      (mode),
        .enable    (enable),
        .out_ready (out_ready),
        .out       (o20),
        .out_valid (v20),
        .out_ch    (ch20),
        .scan_wrap (w20),
        .sel_err   (e20)
    );

    // Behavioural reference: what the block holds after the coming clock edge.
    function automatic void step(inout mstate_t s, input int n);
        int c;
        bit restart;
        if (rst) begin
            s.cnt = 0; s.mode_q = 0; s.valid = 0; s.data = '0;
            s.ch = 0; s.wrap = 0; s.err = 0;
            return;
        end
        s.err = 0;
        if (enable) begin
            s.valid = 0; s.data = '0; s.wrap = 0;
        end else if (!s.valid || out_ready) begin
            restart = (mode != s.mode_q);
            if (mode) begin
                c = restart ? 0 : s.cnt;
                s.cnt = (c + 1) % n;
            end else begin
                c = int'(sel);
                if (restart) s.cnt = 0;
            end
            if (c < n) begin
                s.valid = 1;
                s.data  = in_bus[c*W +: W];
                s.ch    = c;
                s.wrap  = mode && (c == n - 1);
            end else begin
                s.valid = 0; s.data = '0; s.wrap = 0; s.err = 1;
            end
        end
        s.mode_q = mode;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input mstate_t e, input logic v,
                             input logic [7:0] o, input logic [4:0] c,
                             input logic w, input logic er);
        chk({tag, " out_valid"}, 32'(v), 32'(e.valid));
        chk({tag, " out"},       32'(o), 32'(e.data));
        chk({tag, " scan_wrap"}, 32'(w), 32'(e.wrap));
        chk({tag, " sel_err"},   32'(er), 32'(e.err));
        if (e.valid) chk({tag, " out_ch"}, 32'(c), 32'(e.ch));
    endtask

    // Monitor: every cycle the DUTs present a snapshot; compare it with the queued prediction.
    initial begin
        mstate_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check_dut("d32", e, v32, o32, ch32, w32, e32);
            end
            if (q20.size() != 0) begin
                e = q20.pop_front();
                check_dut("d20", e, v20, o20, ch20, w20, e20);
            end
        end
    end

    // One clock: predict both models from the driven inputs, queue them, move to the next negedge.
    task automatic tick();
        step(m32, 32);
        step(m20, 20);
        q32.push_back(m32);
        q20.push_back(m20);
        @(negedge clk);
    endtask

    task automatic set_ctl(input bit r, input bit en, input bit md, input int s, input bit rdy);
        rst = r; enable = en; mode = md; sel = 5'(s); out_ready = rdy;
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 32; k++) in_bus[k*W +: W] = W'(k + 'hA0);
    endtask

    initial begin
        m32 = '{default: 0};
        m20 = '{default: 0};
        fill_pattern();

        // Reset, including a cycle where every other input asks for a capture.
        set_ctl(1, 0, 0, 0, 0); tick();
        set_ctl(1, 0, 1, 7, 1); tick();

        // Direct sweep of all selects; channels 20..31 are illegal for the 20-channel part.
        for (int s = 0; s < 32; s++) begin
            set_ctl(0, 0, 0, s, 1); tick();
        end

        // Stall holds the captured sample while sel changes underneath.
        set_ctl(0, 0, 0, 5, 1); tick();
        repeat (4) begin set_ctl(0, 0, 0, 9, 0); tick(); end
        set_ctl(0, 0, 0, 9, 1); tick();
        set_ctl(0, 0, 0, 2, 0); tick();

        // Scan passes with wrap, then two more to park the 20-channel counter at 7.
        repeat (47) begin set_ctl(0, 0, 1, 0, 1); tick(); end

        // Disable mid-scan, then resume from the frozen counter.
        repeat (3) begin set_ctl(0, 1, 1, 0, 1); tick(); end
        repeat (5) begin set_ctl(0, 0, 1, 0, 1); tick(); end

        // Illegal direct select, then a normal one.
        set_ctl(0, 0, 0, 25, 1); tick();
        set_ctl(0, 0, 0, 3, 1); tick();

        // Scan up to 12, hop through direct, come back: scan restarts at channel 0.
        repeat (12) begin set_ctl(0, 0, 1, 0, 1); tick(); end
        repeat (2) begin set_ctl(0, 0, 0, 4, 1); tick(); end
        repeat (3) begin set_ctl(0, 0, 1, 0, 1); tick(); end

        // Reset while FULL and stalled, with and without out_ready.
        set_ctl(0, 0, 1, 0, 0); tick();
        set_ctl(1, 0, 1, 0, 1); tick();
        set_ctl(1, 0, 1, 0, 0); tick();
        repeat (4) begin set_ctl(0, 0, 1, 0, 1); tick(); end

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 8; k++) in_bus[k*32 +: 32] = $urandom();
            rst       = ($urandom_range(0, 63) == 0);
            enable    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        @(posedge clk);
        #2;
        chk("d32 queue drained", 32'(q32.size()), 32'd0);
        chk("d20 queue drained", 32'(q20.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_nto1_reg_scan
